// File: rtl/taillight_seq.sv
// Tail-lamp sequencer: hazard flash, left/right sweep, park and brake overlay
// for LAMPS lamps per side, with a mode code for the seven-segment driver.
module taillight_seq #(
    parameter int CLK_HZ     = 12_000_000,
    parameter int STEP_HZ    = 4,
    parameter int LAMPS      = 3,
    parameter bit ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic             brake,
    output logic [LAMPS-1:0] lamp_l,
    output logic [LAMPS-1:0] lamp_r,
    output logic [3:0]       mode_code,
    output logic             tick
);

    localparam int TC_RAW = CLK_HZ / STEP_HZ - 1;
    localparam int TC     = (TC_RAW < 1) ? 1 : TC_RAW;
    localparam int PW     = $clog2(TC + 1);
    localparam int SW     = $clog2(LAMPS + 1);

    localparam logic [PW-1:0]    TC_P     = PW'(TC);
    localparam logic [SW-1:0]    STEP_MAX = SW'(LAMPS);
    localparam logic [LAMPS-1:0] ALL      = {LAMPS{1'b1}};
    localparam logic [LAMPS-1:0] POL      = {LAMPS{ACTIVE_LOW}};

    typedef enum logic [2:0] {
        M_OFF    = 3'd0,
        M_HAZARD = 3'd1,
        M_LEFT   = 3'd2,
        M_RIGHT  = 3'd3,
        M_PARK   = 3'd4,
        M_RSV5   = 3'd5,
        M_RSV6   = 3'd6,
        M_RSV7   = 3'd7
    } mode_t;

    logic [2:0]       mode_m, mode_s;
    logic             brake_m, brake_s;
    mode_t            mode_q;
    logic [PW-1:0]    presc;
    logic [SW-1:0]    step;
    logic             phase;
    logic             change;
    logic [LAMPS-1:0] lit_l, lit_r, sweep;

    // Bits [s-1:0] set: the number of lit lamps equals the sweep step.
    function automatic logic [LAMPS-1:0] sweep_mask(input logic [SW-1:0] s);
        logic [LAMPS-1:0] m;
        m = '0;
        for (int i = 0; i < LAMPS; i++)
            m[i] = (SW'(i) < s);
        return m;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_m  <= '0;
            mode_s  <= '0;
            brake_m <= 1'b0;
            brake_s <= 1'b0;
        end else begin
            mode_m  <= mode;
            mode_s  <= mode_m;
            brake_m <= brake;
            brake_s <= brake_m;
        end
    end

    assign change = (mode_t'(mode_s) != mode_q);

    // A mode change restarts the animation at its first visible frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= M_OFF;
            presc  <= '0;
            step   <= '0;
            phase  <= 1'b0;
            tick   <= 1'b0;
        end else if (change) begin
            mode_q <= mode_t'(mode_s);
            presc  <= '0;
            step   <= SW'(1);
            phase  <= 1'b1;
            tick   <= 1'b0;
        end else if (presc == TC_P) begin
            presc  <= '0;
            tick   <= 1'b1;
            phase  <= ~phase;
            step   <= (step == STEP_MAX) ? '0 : step + 1'b1;
        end else begin
            presc  <= presc + 1'b1;
            tick   <= 1'b0;
        end
    end

    assign sweep = sweep_mask(step);

    always_comb begin
        lit_l = '0;
        lit_r = '0;
        case (mode_q)
            M_HAZARD: begin
                lit_l = {LAMPS{phase}};
                lit_r = {LAMPS{phase}};
            end
            M_LEFT: begin
                lit_l = sweep;
                lit_r = brake_s ? ALL : '0;
            end
            M_RIGHT: begin
                lit_l = brake_s ? ALL : '0;
                lit_r = sweep;
            end
            M_PARK: begin
                lit_l = ALL;
                lit_r = ALL;
            end
            default: begin
                lit_l = brake_s ? ALL : '0;
                lit_r = brake_s ? ALL : '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lamp_l    <= POL;
            lamp_r    <= POL;
            mode_code <= 4'h0;
        end else begin
            lamp_l    <= lit_l ^ POL;
            lamp_r    <= lit_r ^ POL;
            mode_code <= (mode_q <= M_PARK) ? {1'b0, mode_q} : 4'hF;
        end
    end

endmodule

// File: tb/tb_taillight_seq.sv
// Directed bench for taillight_seq: expected lamp frames are queued with the
// cycle they are due and compared when that cycle arrives.
module tb_taillight_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] mode;
    logic       brake;
    logic [2:0] lamp_l, lamp_r;
    logic [3:0] mode_code;
    logic       tick;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int         due;
        string      tag;
        logic [2:0] l;
        logic [2:0] r;
        logic [3:0] code;
    } exp_t;

    exp_t sb[$];

    taillight_seq #(
        .CLK_HZ(20), .STEP_HZ(2), .LAMPS(3), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .brake(brake),
        .lamp_l(lamp_l), .lamp_r(lamp_r), .mode_code(mode_code), .tick(tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(int due, string tag, logic [2:0] l, logic [2:0] r,
                                 logic [3:0] code);
        exp_t e;
        e.due = due; e.tag = tag; e.l = l; e.r = r; e.code = code;
        sb.push_back(e);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic adv(int n);
        repeat (n) @(negedge clk);
    endtask

    exp_t e;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            assert (e.due == cyc && lamp_l === e.l && lamp_r === e.r && mode_code === e.code)
            else begin
                errors++;
                $error("FAIL %s: lamp_l=%b lamp_r=%b mode_code=%h at cyc %0d, expected %b %b %h at cyc %0d",
                       e.tag, lamp_l, lamp_r, mode_code, cyc, e.l, e.r, e.code, e.due);
            end
        end
    end

    initial begin
        int c, r, found;
        rst = 1'b1; mode = 3'b000; brake = 1'b0;
        #1;
        chk("por_lamp_l", 32'(lamp_l), 32'h7);
        chk("por_lamp_r", 32'(lamp_r), 32'h7);
        chk("por_code",   32'(mode_code), 32'h0);
        chk("por_tick",   32'(tick), 32'h0);
        adv(2);
        rst = 1'b0;

        // Idle OFF: tick period
        found = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (tick) begin found = 1; break; end
        end
        chk("tick_first", 32'(found), 32'h1);
        push(cyc + 1, "off_idle", 3'b111, 3'b111, 4'h0);
        adv(5);  chk("tick_low_mid", 32'(tick), 32'h0);
        adv(5);  chk("tick_period", 32'(tick), 32'h1);
        adv(3);

        // LEFT sweep, then mid-sweep switch to RIGHT
        c = cyc; mode = 3'b010;
        push(c + 3,  "left_pre",  3'b111, 3'b111, 4'h0);
        push(c + 4,  "left_s1",   3'b110, 3'b111, 4'h2);
        push(c + 14, "left_s2",   3'b100, 3'b111, 4'h2);
        push(c + 24, "left_s3",   3'b000, 3'b111, 4'h2);
        push(c + 34, "left_s0",   3'b111, 3'b111, 4'h2);
        push(c + 44, "left_s1b",  3'b110, 3'b111, 4'h2);
        push(c + 54, "left_s2b",  3'b100, 3'b111, 4'h2);
        adv(13); chk("tick_left", 32'(tick), 32'h1);
        adv(47);
        mode = 3'b011;
        push(c + 64, "right_s1",  3'b111, 3'b110, 4'h3);
        push(c + 74, "right_s2",  3'b111, 3'b100, 4'h3);
        adv(3);  chk("no_tick_change", 32'(tick), 32'h0);
        adv(10); chk("tick_restart", 32'(tick), 32'h1);
        adv(3);

        // HAZARD, brake ignored, then async reset mid-animation
        c = cyc; mode = 3'b001;
        push(c + 4,  "haz_on1",   3'b000, 3'b000, 4'h1);
        push(c + 14, "haz_off1",  3'b111, 3'b111, 4'h1);
        push(c + 24, "haz_on2",   3'b000, 3'b000, 4'h1);
        adv(25);
        brake = 1'b1;
        push(c + 34, "haz_brk_off", 3'b111, 3'b111, 4'h1);
        push(c + 44, "haz_brk_on",  3'b000, 3'b000, 4'h1);
        adv(21);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_l", 32'(lamp_l), 32'h7);
        chk("rst_async_r", 32'(lamp_r), 32'h7);
        chk("rst_async_code", 32'(mode_code), 32'h0);
        adv(3);
        rst = 1'b0; r = cyc;
        push(r + 2, "rel_dark",    3'b111, 3'b111, 4'h0);
        push(r + 3, "rel_brake",   3'b000, 3'b000, 4'h0);
        push(r + 4, "rel_hazard",  3'b000, 3'b000, 4'h1);
        adv(6);

        // RIGHT with brake: left steady lit
        c = cyc; mode = 3'b011;
        push(c + 4,  "rb_s1", 3'b000, 3'b110, 4'h3);
        push(c + 14, "rb_s2", 3'b000, 3'b100, 4'h3);
        push(c + 24, "rb_s3", 3'b000, 3'b000, 4'h3);
        push(c + 34, "rb_s0", 3'b000, 3'b111, 4'h3);
        adv(35);
        mode = 3'b000; brake = 1'b0;
        push(cyc + 6, "off_dark", 3'b111, 3'b111, 4'h0);
        adv(6);
        c = cyc; brake = 1'b1;
        push(c + 2, "brk_lat2", 3'b111, 3'b111, 4'h0);
        push(c + 3, "brk_lat3", 3'b000, 3'b000, 4'h0);
        adv(4);
        brake = 1'b0;
        adv(4);

        // Reserved mode, then PARK
        c = cyc; mode = 3'b110;
        push(c + 3, "rsv_pre", 3'b111, 3'b111, 4'h0);
        push(c + 4, "rsv",     3'b111, 3'b111, 4'hF);
        adv(5);
        c = cyc; mode = 3'b100;
        push(c + 4,  "park1", 3'b000, 3'b000, 4'h4);
        push(c + 15, "park2", 3'b000, 3'b000, 4'h4);
        push(c + 25, "park3", 3'b000, 3'b000, 4'h4);

        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
